uart_rx_ctrl: RTL and testbench

// - Receive-side frame sequencer for the UART RX path. Sits between the synchronised-RX / start-edge

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_bit_timer.sv | 40 ++++
 rtl/uart_rx_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_rx_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    DATA_BITS_5 = 2'd0,
    DATA_BITS_6 = 2'd1,
    DATA_BITS_7 = 2'd2,
    DATA_BITS_8 = 2'd3
  } data_bits_e;

  // Index of the final data bit: 5..8 bits map onto 4..7, i.e. the encoding with a leading one.
  function automatic logic [2:0] last_bit_idx(data_bits_e bits);
    return {1'b1, bits};
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Oversampling tick counter; strobes on the tick that lands mid-start-bit and on each full-bit boundary.
module uart_rx_bit_timer #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_clear,
  output logic o_mid_sample,
  output logic o_full_sample
);

  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_tick) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Strobes are not gated by i_clear: the FSM raises clear in response to them.
  assign o_mid_sample  = i_tick && (cnt_q == MID_CNT);
  assign o_full_sample = i_tick && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start validation, 5..8 data bits LSB-first, optional parity,
// 1/2 stop bits, and a one-entry valid/ready holding register with overrun detection.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter  int OVERSAMPLE = OVERSAMPLE_DEF,
  localparam int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_en,
  input  logic       i_baud_tick,
  input  logic       i_rx_in,
  input  logic       i_start_signal,
  input  logic [1:0] i_cfg_data_bits,
  input  logic       i_cfg_parity_en,
  input  logic       i_cfg_parity_odd,
  input  logic       i_cfg_stop2,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_overrun_err,
  output logic       o_busy
);

  rx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;
  logic       done_q, done_d;
  data_bits_e cfg_bits_q, cfg_bits_d;
  logic       cfg_par_en_q, cfg_par_en_d;
  logic       cfg_par_odd_q, cfg_par_odd_d;
  logic       cfg_stop2_q, cfg_stop2_d;

  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_perr_q, hold_perr_d;
  logic       hold_ferr_q, hold_ferr_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;
  logic       accept;

  logic tmr_clear, mid_sample, full_sample;

  uart_rx_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE),
    .CNT_W     (CNT_W)
  ) u_bit_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_tick       (i_baud_tick),
    .i_clear      (tmr_clear),
    .o_mid_sample (mid_sample),
    .o_full_sample(full_sample)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_err_d     = par_err_q;
    frm_err_d     = frm_err_q;
    done_d        = 1'b0;
    cfg_bits_d    = cfg_bits_q;
    cfg_par_en_d  = cfg_par_en_q;
    cfg_par_odd_d = cfg_par_odd_q;
    cfg_stop2_d   = cfg_stop2_q;
    tmr_clear     = 1'b0;

    case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        if (i_start_signal && i_rx_en) begin
          state_d       = START;
          bit_cnt_d     = '0;
          shift_d       = '0;
          par_err_d     = 1'b0;
          frm_err_d     = 1'b0;
          cfg_bits_d    = data_bits_e'(i_cfg_data_bits);
          cfg_par_en_d  = i_cfg_parity_en;
          cfg_par_odd_d = i_cfg_parity_odd;
          cfg_stop2_d   = i_cfg_stop2;
        end
      end
      START: begin
        if (mid_sample) begin
          // From here on, samples fall mid-bit one full period apart.
          state_d   = i_rx_in ? IDLE : DATA;
          tmr_clear = 1'b1;
        end
      end
      DATA: begin
        if (full_sample) begin
          shift_d[bit_cnt_q] = i_rx_in;
          if (bit_cnt_q == last_bit_idx(cfg_bits_q)) begin
            bit_cnt_d = '0;
            state_d   = cfg_par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (full_sample) begin
          par_err_d = (^shift_q) ^ i_rx_in ^ cfg_par_odd_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (full_sample) begin
          if (!i_rx_in) frm_err_d = 1'b1;
          if (!cfg_stop2_q || bit_cnt_q[0]) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_rx_en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      done_d    = 1'b0;
      tmr_clear = 1'b1;
    end
  end

  assign accept = valid_q && i_rx_ready;

  // A completed frame may replace the held one only when that one leaves in the same cycle.
  always_comb begin
    hold_data_d = hold_data_q;
    hold_perr_d = hold_perr_q;
    hold_ferr_d = hold_ferr_q;
    valid_d     = valid_q;
    ovr_d       = 1'b0;
    if (done_q) begin
      if (!valid_q || accept) begin
        hold_data_d = shift_q;
        hold_perr_d = par_err_q;
        hold_ferr_d = frm_err_q;
        valid_d     = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      frm_err_q     <= 1'b0;
      done_q        <= 1'b0;
      cfg_bits_q    <= DATA_BITS_5;
      cfg_par_en_q  <= 1'b0;
      cfg_par_odd_q <= 1'b0;
      cfg_stop2_q   <= 1'b0;
      hold_data_q   <= '0;
      hold_perr_q   <= 1'b0;
      hold_ferr_q   <= 1'b0;
      valid_q       <= 1'b0;
      ovr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_err_q     <= par_err_d;
      frm_err_q     <= frm_err_d;
      done_q        <= done_d;
      cfg_bits_q    <= cfg_bits_d;
      cfg_par_en_q  <= cfg_par_en_d;
      cfg_par_odd_q <= cfg_par_odd_d;
      cfg_stop2_q   <= cfg_stop2_d;
      hold_data_q   <= hold_data_d;
      hold_perr_q   <= hold_perr_d;
      hold_ferr_q   <= hold_ferr_d;
      valid_q       <= valid_d;
      ovr_q         <= ovr_d;
    end
  end

  assign o_rx_data     = hold_data_q;
  assign o_rx_valid    = valid_q;
  assign o_parity_err  = hold_perr_q;
  assign o_frame_err   = hold_ferr_q;
  assign o_overrun_err = ovr_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed frames against a frame-level model of uart_rx_ctrl (OVERSAMPLE=16, tick every cycle).
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int OS = 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_rx_en = 1'b0;
  logic       i_baud_tick = 1'b1;
  logic       i_rx_in = 1'b1;
  logic       i_start_signal = 1'b0;
  logic [1:0] i_cfg_data_bits = 2'd3;
  logic       i_cfg_parity_en = 1'b0;
  logic       i_cfg_parity_odd = 1'b0;
  logic       i_cfg_stop2 = 1'b0;
  logic       i_rx_ready = 1'b0;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, o_parity_err, o_frame_err, o_overrun_err, o_busy;

  uart_rx_ctrl #(.OVERSAMPLE(OS)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_rx_en         (i_rx_en),
    .i_baud_tick     (i_baud_tick),
    .i_rx_in         (i_rx_in),
    .i_start_signal  (i_start_signal),
    .i_cfg_data_bits (i_cfg_data_bits),
    .i_cfg_parity_en (i_cfg_parity_en),
    .i_cfg_parity_odd(i_cfg_parity_odd),
    .i_cfg_stop2     (i_cfg_stop2),
    .o_rx_data       (o_rx_data),
    .o_rx_valid      (o_rx_valid),
    .i_rx_ready      (i_rx_ready),
    .o_parity_err    (o_parity_err),
    .o_frame_err     (o_frame_err),
    .o_overrun_err   (o_overrun_err),
    .o_busy          (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // cyc = index of the most recent rising edge
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected completions, written by the stimulus, consumed by the model.
  int         e_edge[64];
  logic [7:0] e_data[64];
  bit         e_perr[64];
  bit         e_ferr[64];
  int         wr = 0;
  int         b_start = 0;
  int         b_end = 0;

  // Monitors used by the literal checks.
  int   rise_cyc = 0;
  int   ovr_cnt = 0;
  logic valid_prev = 1'b0;
  always @(negedge i_clk) begin
    if (o_rx_valid && !valid_prev) rise_cyc <= cyc;
    if (o_overrun_err) ovr_cnt <= ovr_cnt + 1;
    valid_prev <= o_rx_valid;
  end

  // Holding-register model, checked against the DUT on every falling edge.
  initial begin
    int         rd;
    bit         m_valid, m_perr, m_ferr, m_ovr, acc;
    logic [7:0] m_data;
    rd = 0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_data = 8'h00;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        rd = wr; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_data = 8'h00;
        check("rst_valid", o_rx_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_data", o_rx_data, 0);
        check("rst_ovr", o_overrun_err, 0);
      end else begin
        check("m_valid", o_rx_valid, m_valid);
        check("m_busy", o_busy, (cyc >= b_start && cyc < b_end));
        check("m_overrun", o_overrun_err, m_ovr);
        if (m_valid) begin
          check("m_data", o_rx_data, m_data);
          check("m_perr", o_parity_err, m_perr);
          check("m_ferr", o_frame_err, m_ferr);
        end
        m_ovr = 0;
        acc = m_valid && i_rx_ready;
        if (rd != wr && e_edge[rd] == cyc + 1) begin
          if (!m_valid || acc) begin
            m_valid = 1; m_data = e_data[rd]; m_perr = e_perr[rd]; m_ferr = e_ferr[rd];
          end else begin
            m_ovr = 1;
          end
          rd++;
        end else if (acc) begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic wait_edge(input int n);
    while (cyc < n) @(negedge i_clk);
  endtask

  task automatic drain();
    @(posedge i_clk); #1;
    i_rx_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rx_ready = 1'b0;
  endtask

  // Drives one frame bit-by-bit; abort_idx>0 stops at that bit (0=start) via rx_en low or reset.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                            input bit pbit, input bit s2, input bit [1:0] stops,
                            input int abort_idx, input bit abort_rst, output int s);
    bit         bits[12];
    int         len;
    logic [7:0] dm;
    dm = d & 8'((1 << nb) - 1);
    len = 0;
    bits[len] = 1'b0; len = len + 1;
    for (int i = 0; i < nb; i++) begin bits[len] = d[i]; len = len + 1; end
    if (pen) begin bits[len] = pbit; len = len + 1; end
    bits[len] = stops[0]; len = len + 1;
    if (s2) begin bits[len] = stops[1]; len = len + 1; end
    @(posedge i_clk); #1;
    s = cyc + 1;
    b_start = s;
    b_end = (abort_idx > 0) ? s + OS * abort_idx : s + OS / 2 + OS * (len - 1);
    if (abort_idx == 0) begin
      e_edge[wr] = s + OS / 2 + OS * (len - 1) + 1;
      e_data[wr] = dm;
      e_perr[wr] = pen && ((($countones(dm) + pbit + podd) % 2) == 1);
      e_ferr[wr] = !stops[0] || (s2 && !stops[1]);
      wr++;
    end
    i_cfg_data_bits  = 2'(nb - 5);
    i_cfg_parity_en  = pen;
    i_cfg_parity_odd = podd;
    i_cfg_stop2      = s2;
    for (int i = 0; i < len; i++) begin
      if (abort_idx > 0 && i == abort_idx) begin
        if (abort_rst) i_rst_n = 1'b0;
        else i_rx_en = 1'b0;
        break;
      end
      i_rx_in = bits[i];
      for (int j = 0; j < OS; j++) begin
        i_start_signal = (i == 0 && j == 0);
        @(posedge i_clk); #1;
      end
    end
    i_start_signal = 1'b0;
    i_rx_in = 1'b1;
    $display("frame start=%0d data=%02h bits=%0d par=%0d odd=%0d pbit=%0d stop2=%0d stops=%b abort=%0d",
             s, d, nb, pen, podd, pbit, s2, stops, abort_idx);
  endtask

  initial begin
    int s;
    int ovr0;
    #1 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_valid", o_rx_valid, 0);
    check("reset_data", o_rx_data, 0);
    check("reset_perr", o_parity_err, 0);
    check("reset_ferr", o_frame_err, 0);
    check("reset_ovr", o_overrun_err, 0);
    check("reset_busy", o_busy, 0);
    i_rst_n = 1'b1;
    i_rx_en = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;

    // 8N1 0xA5: valid 8+9*16 ticks + 1 clk after the start edge
    send_frame(8'hA5, 8, 0, 0, 0, 0, 2'b11, 0, 0, s);
    check("a5_data", o_rx_data, 8'hA5);
    check("a5_valid", o_rx_valid, 1);
    check("a5_latency", rise_cyc - s, 153);
    check("a5_perr", o_parity_err, 0);
    check("a5_ferr", o_frame_err, 0);
    drain();

    // False start: line low for 4 ticks only
    @(posedge i_clk); #1;
    s = cyc + 1;
    b_start = s;
    b_end = s + 8;
    i_start_signal = 1'b1;
    i_rx_in = 1'b0;
    @(posedge i_clk); #1;
    i_start_signal = 1'b0;
    repeat (3) begin @(posedge i_clk); #1; end
    i_rx_in = 1'b1;
    wait_edge(s + 7);
    check("false_busy_7", o_busy, 1);
    wait_edge(s + 8);
    check("false_busy_8", o_busy, 0);
    repeat (20) @(posedge i_clk);
    #1;
    check("false_novalid", o_rx_valid, 0);

    // 8E1 0x03 with wrong then right parity bit
    send_frame(8'h03, 8, 1, 0, 1, 0, 2'b11, 0, 0, s);
    check("e1_bad_data", o_rx_data, 8'h03);
    check("e1_bad_perr", o_parity_err, 1);
    drain();
    send_frame(8'h03, 8, 1, 0, 0, 0, 2'b11, 0, 0, s);
    check("e1_ok_perr", o_parity_err, 0);
    drain();

    // 8N2 with the second stop bit low
    send_frame(8'h3C, 8, 0, 0, 0, 1, 2'b01, 0, 0, s);
    check("n2_ferr", o_frame_err, 1);
    check("n2_data", o_rx_data, 8'h3C);
    drain();

    // 5N1 0x1F, then 6O1 with 0xFF on the wire (upper bits must read 0)
    send_frame(8'h1F, 5, 0, 0, 0, 0, 2'b11, 0, 0, s);
    check("5n1_data", o_rx_data, 8'h1F);
    drain();
    send_frame(8'hFF, 6, 1, 1, 1, 0, 2'b11, 0, 0, s);
    check("6o1_data", o_rx_data, 8'h3F);
    check("6o1_perr", o_parity_err, 0);
    drain();

    // Overrun: two frames, consumer not ready
    ovr0 = ovr_cnt;
    send_frame(8'h11, 8, 0, 0, 0, 0, 2'b11, 0, 0, s);
    send_frame(8'h22, 8, 0, 0, 0, 0, 2'b11, 0, 0, s);
    repeat (2) @(posedge i_clk);
    #1;
    check("ovr_data", o_rx_data, 8'h11);
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    drain();

    // Receiver disabled after 3 data bits, then a clean frame
    send_frame(8'h5A, 8, 0, 0, 0, 0, 2'b11, 4, 0, s);
    wait_edge(s + 64);
    check("abort_busy", o_busy, 0);
    repeat (3) @(posedge i_clk);
    #1;
    check("abort_novalid", o_rx_valid, 0);
    i_rx_en = 1'b1;
    send_frame(8'h5A, 8, 0, 0, 0, 0, 2'b11, 0, 0, s);
    check("reen_data", o_rx_data, 8'h5A);
    check("reen_ferr", o_frame_err, 0);

    // Reset mid-frame discards the undelivered 0x5A as well
    send_frame(8'h88, 8, 0, 0, 0, 0, 2'b11, 3, 1, s);
    @(negedge i_clk);
    check("rstmid_valid", o_rx_valid, 0);
    check("rstmid_data", o_rx_data, 0);
    check("rstmid_busy", o_busy, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    send_frame(8'hC3, 8, 1, 1, 0, 0, 2'b11, 0, 0, s);
    check("post_rst_data", o_rx_data, 8'hC3);
    check("post_rst_perr", o_parity_err, 1);
    drain();

    repeat (5) @(posedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, got cycle %0d expected end before 100000", cyc);
    $fatal(1);
  end

endmodule
